// File: rtl/cook_timer.sv
// MM:SS BCD countdown timer: keypad digit entry, 1 Hz countdown while mag_on, timer_done on 0:00.
// Optional +0:30 strobe input and adder are built only when COOK_TIMER_ADD30_EN is defined.
module cook_timer #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       mag_on,
`ifdef COOK_TIMER_ADD30_EN
  input  logic       add30,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          st_q;
  logic [PW-1:0]   presc;
  logic            is_zero;
  logic            tick;
  logic            entry;
  logic            entry_nonzero;
  logic [3:0]      d_mt, d_mo, d_st, d_so;
  logic            dec_zero;

  assign state         = st_q;
  assign is_zero       = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
  assign tick          = mag_on && !is_zero && (presc == PW'(TICKS_PER_SEC - 1));
  assign entry         = digit_valid && !mag_on && (digit <= 4'd9);
  assign entry_nonzero = ({min_ones, sec_tens, sec_ones, digit} != 16'h0000);

  // BCD decrement with borrow chain; only used when the count is nonzero.
  always_comb begin
    d_mt = min_tens;
    d_mo = min_ones;
    d_st = sec_tens;
    d_so = sec_ones;
    if (sec_ones != 4'd0) begin
      d_so = sec_ones - 4'd1;
    end else begin
      d_so = 4'd9;
      if (sec_tens != 4'd0) begin
        d_st = sec_tens - 4'd1;
      end else begin
        d_st = 4'd5;
        if (min_ones != 4'd0) begin
          d_mo = min_ones - 4'd1;
        end else begin
          d_mo = 4'd9;
          d_mt = min_tens - 4'd1;
        end
      end
    end
    dec_zero = ({d_mt, d_mo, d_st, d_so} == 16'h0000);
  end

`ifdef COOK_TIMER_ADD30_EN
  logic [4:0] a_t;
  logic [4:0] a_mo_s;
  logic [4:0] a_mt_s;
  logic [1:0] a_c;
  logic [3:0] a_mt, a_mo, a_st, a_so;

  // Entered seconds tens may be up to 9, so +3 can need up to two minute carries.
  always_comb begin
    a_t    = {1'b0, sec_tens} + 5'd3;
    a_c    = 2'd0;
    if (a_t >= 5'd12) begin
      a_t = a_t - 5'd12;
      a_c = 2'd2;
    end else if (a_t >= 5'd6) begin
      a_t = a_t - 5'd6;
      a_c = 2'd1;
    end
    a_mo_s = {1'b0, min_ones} + {3'b000, a_c};
    a_mt_s = {1'b0, min_tens};
    if (a_mo_s > 5'd9) begin
      a_mo_s = a_mo_s - 5'd10;
      a_mt_s = a_mt_s + 5'd1;
    end
    if (a_mt_s > 5'd9) begin
      a_mt = 4'd9;
      a_mo = 4'd9;
      a_st = 4'd5;
      a_so = 4'd9;
    end else begin
      a_mt = a_mt_s[3:0];
      a_mo = a_mo_s[3:0];
      a_st = a_t[3:0];
      a_so = sec_ones;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || !clearn) begin
      min_tens   <= '0;
      min_ones   <= '0;
      sec_tens   <= '0;
      sec_ones   <= '0;
      presc      <= '0;
      timer_done <= 1'b0;
      st_q       <= IDLE;
    end
`ifdef COOK_TIMER_ADD30_EN
    else if (add30) begin
      min_tens   <= a_mt;
      min_ones   <= a_mo;
      sec_tens   <= a_st;
      sec_ones   <= a_so;
      presc      <= '0;
      timer_done <= 1'b0;
      st_q       <= mag_on ? RUN : SET;
    end
`endif
    else if (entry) begin
      min_tens   <= min_ones;
      min_ones   <= sec_tens;
      sec_tens   <= sec_ones;
      sec_ones   <= digit;
      presc      <= '0;
      timer_done <= 1'b0;
      st_q       <= entry_nonzero ? SET : IDLE;
    end else if (mag_on && !is_zero) begin
      if (tick) begin
        presc    <= '0;
        min_tens <= d_mt;
        min_ones <= d_mo;
        sec_tens <= d_st;
        sec_ones <= d_so;
        if (dec_zero) begin
          timer_done <= 1'b1;
          st_q       <= DONE;
        end else begin
          st_q <= RUN;
        end
      end else begin
        presc <= presc + PW'(1);
        st_q  <= RUN;
      end
    end else if (!is_zero) begin
      // Paused with time remaining: prescaler holds so the partial second resumes.
      st_q <= SET;
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Directed self-checking bench for cook_timer with TICKS_PER_SEC=4.
// Add30 checks are built only when COOK_TIMER_ADD30_EN is defined.
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clearn;
  logic       digit_valid;
  logic [3:0] digit;
  logic       mag_on;
`ifdef COOK_TIMER_ADD30_EN
  logic       add30;
`endif
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_SET = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3;

  cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clearn     (clearn),
    .digit_valid(digit_valid),
    .digit      (digit),
    .mag_on     (mag_on),
`ifdef COOK_TIMER_ADD30_EN
    .add30      (add30),
`endif
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    step(1);
    digit_valid = 1'b0;
    digit       = 4'd0;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp_d,
                       input logic exp_done, input logic [1:0] exp_st);
    logic [18:0] obs;
    logic [18:0] expv;
    obs  = {min_tens, min_ones, sec_tens, sec_ones, timer_done, state};
    expv = {exp_d, exp_done, exp_st};
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h:%h done=%b st=%0d, expected %h:%h done=%b st=%0d",
             tag, obs[18:11], obs[10:3], obs[2], obs[1:0],
             expv[18:11], expv[10:3], expv[2], expv[1:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clearn      = 1'($urandom_range(1, 0));
      digit_valid = 1'($urandom_range(1, 0));
      digit       = 4'($urandom_range(15, 0));
      mag_on      = 1'($urandom_range(1, 0));
`ifdef COOK_TIMER_ADD30_EN
      add30       = 1'($urandom_range(1, 0));
`endif
      step(1);
    end
    rst = 1'b0; clearn = 1'b1; digit_valid = 1'b0; digit = 4'd0; mag_on = 1'b0;
`ifdef COOK_TIMER_ADD30_EN
    add30 = 1'b0;
`endif
    check("reset", 16'h0000, 1'b0, S_IDLE);

    key(4'd1); key(4'd2); key(4'd3);
    check("keys_123", 16'h0123, 1'b0, S_SET);
    key(4'd11);
    check("key_11_ignored", 16'h0123, 1'b0, S_SET);
    key(4'd4); key(4'd5);
    check("keys_45_shift", 16'h2345, 1'b0, S_SET);
    do_clear();
    check("clear_in_set", 16'h0000, 1'b0, S_IDLE);

    key(4'd2);
    mag_on = 1'b1;
    step(4);
    check("run_002_1s", 16'h0001, 1'b0, S_RUN);
    step(3);
    check("run_002_7clk", 16'h0001, 1'b0, S_RUN);
    step(1);
    check("run_002_done", 16'h0000, 1'b1, S_DONE);
    step(6);
    check("done_mag_on_hold", 16'h0000, 1'b1, S_DONE);
    mag_on = 1'b0;
    step(1);
    check("done_mag_off", 16'h0000, 1'b1, S_DONE);
    key(4'd5);
    check("done_key5", 16'h0005, 1'b0, S_SET);

    do_clear();
    key(4'd1); key(4'd0); key(4'd0);
    mag_on = 1'b1;
    step(4);
    check("borrow_100", 16'h0059, 1'b0, S_RUN);
    mag_on = 1'b0;
    step(1);
    check("pause_to_set", 16'h0059, 1'b0, S_SET);
    key(4'd0); key(4'd0); key(4'd9); key(4'd0);
    mag_on = 1'b1;
    step(4);
    check("borrow_090", 16'h0089, 1'b0, S_RUN);
    mag_on = 1'b0;
    step(1);
    key(4'd0); key(4'd0); key(4'd9); key(4'd9);
    mag_on = 1'b1;
    step(4);
    check("dec_099", 16'h0098, 1'b0, S_RUN);
    mag_on = 1'b0;
    step(1);

    do_clear();
    key(4'd1); key(4'd0);
    mag_on = 1'b1;
    step(2);
    mag_on = 1'b0;
    step(21);
    check("pause_hold", 16'h0010, 1'b0, S_SET);
    mag_on = 1'b1;
    step(1);
    check("resume_partial", 16'h0010, 1'b0, S_RUN);
    step(1);
    check("resume_tick", 16'h0009, 1'b0, S_RUN);
    key(4'd7);
    check("key_in_run_ignored", 16'h0009, 1'b0, S_RUN);
    do_clear();
    check("clear_in_run", 16'h0000, 1'b0, S_IDLE);
    mag_on = 1'b0;

    // Would-be tick coincides with mag_on falling: no decrement.
    key(4'd1); key(4'd0);
    mag_on = 1'b1;
    step(3);
    mag_on = 1'b0;
    step(1);
    check("fall_on_tick", 16'h0010, 1'b0, S_SET);

`ifdef COOK_TIMER_ADD30_EN
    do_clear();
    key(4'd4); key(4'd5);
    add30 = 1'b1; step(1); add30 = 1'b0;
    check("add30_045", 16'h0115, 1'b0, S_SET);
    do_clear();
    key(4'd9); key(4'd9); key(4'd5); key(4'd0);
    add30 = 1'b1; step(1); add30 = 1'b0;
    check("add30_sat", 16'h9959, 1'b0, S_SET);
    do_clear();
    key(4'd1);
    mag_on = 1'b1;
    step(4);
    mag_on = 1'b0;
    add30 = 1'b1; step(1); add30 = 1'b0;
    check("add30_done", 16'h0030, 1'b0, S_SET);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
